// File: rtl/board_io_pkg.sv
// Board-level I/O constants shared by the debouncer, the counter and the top level.
package board_io_pkg;

   localparam int unsigned CLK_HZ       = 125000000;
   localparam int unsigned DEBOUNCE_MS  = 10;

   // Stable cycles needed before a new input level is accepted (10 ms at 125 MHz).
   localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

   // Channel mapping: two slide switches followed by four push buttons.
   localparam int unsigned N_CH_DEF  = 6;
   localparam int unsigned CH_SW_RST = 0;
   localparam int unsigned CH_SW_DIR = 1;
   localparam int unsigned CH_BTN0   = 2;
   localparam int unsigned CH_BTN1   = 3;
   localparam int unsigned CH_BTN2   = 4;
   localparam int unsigned CH_BTN3   = 5;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer, stability counter and edge pulses.
module debounce_channel
   import board_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Synchronize, count consecutive mismatch cycles, accept once the count reaches its maximum.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sync2 == level) begin
            // Any glitch that ends before acceptance is forgotten here.
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync2;
            cnt   <= '0;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/input_debouncer.sv
// Replicates one debounce channel per raw switch/button input.
module input_debouncer
   import board_io_pkg::*;
#(
   parameter int unsigned N_CH            = N_CH_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse
);

   // Independent channels, one per input bit.
   for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_in[i]),
         .level (level_out[i]),
         .rise  (rise_pulse[i]),
         .fall  (fall_pulse[i])
      );
   end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed, table-driven bench for input_debouncer with DEBOUNCE_CYCLES = 4.
module tb_input_debouncer;

   localparam int unsigned N_CH = 6;
   localparam int unsigned DCYC = 4;
   localparam int unsigned N_VEC = 25;

   logic            clk;
   logic            rst;
   logic [N_CH-1:0] raw_in;
   logic [N_CH-1:0] level_out;
   logic [N_CH-1:0] rise_pulse;
   logic [N_CH-1:0] fall_pulse;

   int n_checks;
   int n_pass;

   typedef struct {
      logic       rst;
      logic [5:0] raw;
      logic [5:0] level;
      logic [5:0] rise;
      logic [5:0] fall;
   } vec_t;

   vec_t tbl [N_VEC];

   input_debouncer #(
      .N_CH            (N_CH),
      .DEBOUNCE_CYCLES (DCYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in),
      .level_out  (level_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Drive inputs on the falling edge, check outputs just after the next rising edge.
   task automatic step(input logic r, input logic [5:0] rw, input logic [5:0] lv,
                       input logic [5:0] ri, input logic [5:0] fa, input string tag);
      @(negedge clk);
      rst    = r;
      raw_in = rw;
      @(posedge clk);
      #1;
      chk({tag, " level"}, level_out, lv);
      chk({tag, " rise"},  rise_pulse, ri);
      chk({tag, " fall"},  fall_pulse, fa);
   endtask

   // Apply new_raw at E0 and hold it: level/pulse must change exactly on E5, pulse gone on E6.
   task automatic press(input logic [5:0] old_lvl, input logic [5:0] new_raw,
                        input logic [5:0] ri, input logic [5:0] fa, input string tag);
      for (int k = 0; k <= 6; k++) begin
         if (k < 5)       step(1'b0, new_raw, old_lvl, 6'h00, 6'h00, $sformatf("%s E%0d", tag, k));
         else if (k == 5) step(1'b0, new_raw, new_raw, ri, fa, $sformatf("%s E%0d", tag, k));
         else             step(1'b0, new_raw, new_raw, 6'h00, 6'h00, $sformatf("%s E%0d", tag, k));
      end
   endtask

   initial begin
      logic [5:0] bounce [16];
      logic [5:0] lv;
      logic [5:0] ri;
      logic [5:0] rw;

      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      raw_in   = '0;

      // Reset with all inputs high, release qualification, release of ch3, clean press of ch5.
      for (int i = 0; i < 3; i++)   tbl[i] = '{1'b1, 6'h3F, 6'h00, 6'h00, 6'h00};
      for (int i = 3; i < 8; i++)   tbl[i] = '{1'b0, 6'h3F, 6'h00, 6'h00, 6'h00};
      tbl[8]  = '{1'b0, 6'h3F, 6'h3F, 6'h3F, 6'h00};
      tbl[9]  = '{1'b0, 6'h3F, 6'h3F, 6'h00, 6'h00};
      for (int i = 10; i < 15; i++) tbl[i] = '{1'b0, 6'h37, 6'h3F, 6'h00, 6'h00};
      tbl[15] = '{1'b0, 6'h37, 6'h37, 6'h00, 6'h08};
      tbl[16] = '{1'b0, 6'h37, 6'h37, 6'h00, 6'h00};
      tbl[17] = '{1'b1, 6'h00, 6'h00, 6'h00, 6'h00};
      for (int i = 18; i < 23; i++) tbl[i] = '{1'b0, 6'h20, 6'h00, 6'h00, 6'h00};
      tbl[23] = '{1'b0, 6'h20, 6'h20, 6'h20, 6'h00};
      tbl[24] = '{1'b0, 6'h20, 6'h20, 6'h00, 6'h00};

      for (int i = 0; i < int'(N_VEC); i++)
         step(tbl[i].rst, tbl[i].raw, tbl[i].level, tbl[i].rise, tbl[i].fall,
              $sformatf("vec%0d", i));

      // Bounce on ch2: single-cycle toggles, then 3-cycle bursts, all rejected.
      step(1'b1, 6'h00, 6'h00, 6'h00, 6'h00, "bounce rst");
      bounce = '{6'h04, 6'h00, 6'h04, 6'h00,
                 6'h04, 6'h04, 6'h04, 6'h00, 6'h00, 6'h00,
                 6'h04, 6'h04, 6'h04, 6'h00, 6'h00, 6'h00};
      for (int i = 0; i < 16; i++)
         step(1'b0, bounce[i], 6'h00, 6'h00, 6'h00, $sformatf("bounce%0d", i));
      for (int i = 0; i < 3; i++)
         step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, $sformatf("bounce tail%0d", i));
      press(6'h00, 6'h04, 6'h04, 6'h00, "bounce hold");

      // Reset while ch1 counter is at 2 discards the pending change; full latency again.
      step(1'b1, 6'h00, 6'h00, 6'h00, 6'h00, "midrst clr");
      step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, "midrst idle");
      for (int k = 0; k < 4; k++)
         step(1'b0, 6'h02, 6'h00, 6'h00, 6'h00, $sformatf("midrst E%0d", k));
      step(1'b1, 6'h02, 6'h00, 6'h00, 6'h00, "midrst rst");
      press(6'h00, 6'h02, 6'h02, 6'h00, "midrst requal");

      // Staggered presses: channel i goes high at step i and accepts at step i+5.
      step(1'b1, 6'h00, 6'h00, 6'h00, 6'h00, "stagger rst");
      step(1'b0, 6'h00, 6'h00, 6'h00, 6'h00, "stagger idle");
      for (int s = 0; s < 13; s++) begin
         rw = '0; lv = '0; ri = '0;
         for (int i = 0; i < int'(N_CH); i++) begin
            if (s >= i)     rw[i] = 1'b1;
            if (s >= i + 5) lv[i] = 1'b1;
            if (s == i + 5) ri[i] = 1'b1;
         end
         step(1'b0, rw, lv, ri, 6'h00, $sformatf("stagger s%0d", s));
      end

      // Staggered releases in reverse order.
      for (int s = 0; s < 13; s++) begin
         rw = '1; lv = '1; ri = '0;
         for (int i = 0; i < int'(N_CH); i++) begin
            if (s >= 5 - i)     rw[i] = 1'b0;
            if (s >= 10 - i)    lv[i] = 1'b0;
            if (s == 10 - i)    ri[i] = 1'b1;
         end
         step(1'b0, rw, lv, 6'h00, ri, $sformatf("unstagger s%0d", s));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
